// File: rtl/neuron_mac_seq_pkg.sv
// Shared definitions for the time-multiplexed neuron: default widths,
// FSM state encoding and the saturating accumulator add.
package neuron_mac_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DIFF = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Unsigned add clamped to 2^w-1; a clamped sum stays clamped since addends are magnitudes.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/neuron_mac_seq_mnozenje.sv
// mnozenje: sign-magnitude weight times unsigned sample, Q2.14-scaled magnitude
// product plus the weight sign that selects the accumulator.
module mnozenje #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_w,
  input  logic [DATA_W-1:0] i_s,
  output logic [DATA_W:0]   o_prod,
  output logic              o_neg
);

  logic [2*DATA_W-2:0] w_full;

  assign w_full = {{DATA_W{1'b0}}, i_w[DATA_W-2:0]} * {{(DATA_W-1){1'b0}}, i_s};
  assign o_prod = w_full[2*DATA_W-2:DATA_W-2];
  assign o_neg  = i_w[DATA_W-1];

endmodule

// File: rtl/neuron_mac_seq_sigmoid.sv
// Sigmoid_LUT: piecewise-linear sigmoid around 0x8000; slope 1/64 of |P-N|,
// clipped so the probability stays within 0x0001..0xFFFF.
module Sigmoid_LUT #(
  parameter int ACC_W = 22
) (
  input  logic [ACC_W-1:0] i_suma,
  input  logic             i_predznak,
  output logic [15:0]      o_izlaz
);

  logic [31:0] w_step;
  logic [14:0] w_f;

  assign w_step  = 32'(i_suma) >> 6;
  assign w_f     = (w_step > 32'h0000_7FFF) ? 15'h7FFF : w_step[14:0];
  assign o_izlaz = i_predznak ? (16'h8000 - {1'b0, w_f}) : (16'h8000 + {1'b0, w_f});

endmodule

// File: rtl/neuron_mac_seq.sv
// Streamed neuron: one shared multiplier, writable sign-magnitude weights, separate
// positive/negative saturating sums, |P-N| plus sign mapped through Sigmoid_LUT.
module neuron_mac_seq
  import neuron_mac_seq_pkg::*;
#(
  parameter int N_INPUTS = 60,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wt_we,
  input  logic [IDX_W-1:0]  wt_addr,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       izlaz,
  output logic              predznak,
  output logic              wt_err,
  output logic              frame_err
);

  localparam int               PROD_W   = DATA_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic [IDX_W:0]   N_LIM    = (IDX_W + 1)'(N_INPUTS);

  state_e            r_state;
  logic [IDX_W-1:0]  r_count;
  logic [ACC_W-1:0]  r_p_acc;
  logic [ACC_W-1:0]  r_n_acc;
  logic [DATA_W-1:0] r_wt [N_INPUTS];
  logic              r_s_ready;
  logic              r_out_valid;
  logic [15:0]       r_izlaz;
  logic              r_predznak;
  logic              r_wt_err;
  logic              r_frame_err;

  logic              w_beat;
  logic              w_wt_ok;
  logic              w_is_last;
  logic              w_p_gt;
  logic [DATA_W-1:0] w_wt;
  logic [PROD_W-1:0] w_prod;
  logic              w_neg;
  logic [ACC_W-1:0]  w_mag;
  logic [15:0]       w_lut;

  assign w_beat    = s_valid & r_s_ready;
  assign w_wt      = r_wt[r_count];
  assign w_is_last = (r_count == LAST_IDX);
  assign w_wt_ok   = (r_state == ST_IDLE) && ({1'b0, wt_addr} < N_LIM);
  // A tie counts as negative so the downstream sees a deterministic sign.
  assign w_p_gt    = (r_p_acc > r_n_acc);
  assign w_mag     = w_p_gt ? (r_p_acc - r_n_acc) : (r_n_acc - r_p_acc);

  mnozenje #(.DATA_W(DATA_W)) u_mul (
    .i_w   (w_wt),
    .i_s   (s_data),
    .o_prod(w_prod),
    .o_neg (w_neg)
  );

  Sigmoid_LUT #(.ACC_W(ACC_W)) u_lut (
    .i_suma    (w_mag),
    .i_predznak(~w_p_gt),
    .o_izlaz   (w_lut)
  );

  // Weights only change in IDLE; the index-0 beat in the same cycle still reads the old w[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) r_wt[i] <= '0;
      r_wt_err <= 1'b0;
    end else begin
      if (wt_we && w_wt_ok) r_wt[wt_addr] <= wt_data;
      r_wt_err <= wt_we & ~w_wt_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_p_acc     <= '0;
      r_n_acc     <= '0;
      r_s_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_izlaz     <= 16'h0000;
      r_predznak  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACC: begin
          r_s_ready <= 1'b1;
          if (w_beat) begin
            if (w_neg) r_n_acc <= ACC_W'(sat_add(32'(r_n_acc), 32'(w_prod), ACC_W));
            else       r_p_acc <= ACC_W'(sat_add(32'(r_p_acc), 32'(w_prod), ACC_W));
            if (s_last != w_is_last) r_frame_err <= 1'b1;
            if (w_is_last) begin
              r_count   <= '0;
              r_s_ready <= 1'b0;
              r_state   <= ST_DIFF;
            end else begin
              r_count <= r_count + IDX_W'(1);
              r_state <= ST_ACC;
            end
          end
        end
        ST_DIFF: begin
          r_izlaz     <= w_lut;
          r_predznak  <= ~w_p_gt;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_p_acc     <= '0;
            r_n_acc     <= '0;
            r_s_ready   <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign out_valid = r_out_valid;
  assign izlaz     = r_izlaz;
  assign predznak  = r_predznak;
  assign wt_err    = r_wt_err;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench: two instances (4 and 60 inputs); stimulus pushes expected
// results, a monitor pops and compares on each output handshake.
module tb_neuron_mac_seq;

  typedef struct packed {
    logic [15:0] iz;
    logic        pz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wt_we     [2];
  logic [1:0]  wa4;
  logic [5:0]  wa60;
  logic [15:0] wt_data   [2];
  logic        s_valid   [2];
  logic        s_ready   [2];
  logic [15:0] s_data    [2];
  logic        s_last    [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] izlaz     [2];
  logic        predznak  [2];
  logic        wt_err    [2];
  logic        frame_err [2];

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  neuron_mac_seq #(.N_INPUTS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wt_we(wt_we[0]), .wt_addr(wa4), .wt_data(wt_data[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .izlaz(izlaz[0]),
    .predznak(predznak[0]), .wt_err(wt_err[0]), .frame_err(frame_err[0])
  );

  neuron_mac_seq #(.N_INPUTS(60)) u_dut60 (
    .clk(clk), .rst_n(rst_n), .wt_we(wt_we[1]), .wt_addr(wa60), .wt_data(wt_data[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .izlaz(izlaz[1]),
    .predznak(predznak[1]), .wt_err(wt_err[1]), .frame_err(frame_err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [15:0] iz, input logic pz);
    exp_t e;
    e.iz = iz;
    e.pz = pz;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic set_addr(input int d, input logic [5:0] a);
    if (d == 0) wa4 = a[1:0];
    else        wa60 = a;
  endtask

  // Weight write from posedge+1; ends aligned at posedge+1.
  task automatic wr(input int d, input logic [5:0] a, input logic [15:0] v, input logic exp_err);
    wt_we[d]   = 1'b1;
    set_addr(d, a);
    wt_data[d] = v;
    @(posedge clk); #1;
    wt_we[d] = 1'b0;
    chk($sformatf("d%0d_wt_err_pulse_a%0d", d, a), 32'(wt_err[d]), 32'(exp_err));
    @(posedge clk); #1;
    chk($sformatf("d%0d_wt_err_clear_a%0d", d, a), 32'(wt_err[d]), 32'd0);
  endtask

  task automatic send_beat(input int d, input logic [15:0] v, input logic last,
                           input bit do_wr, input logic [15:0] wv, input logic exp_err);
    bit ok    = 1'b0;
    int guard = 0;
    s_valid[d] = 1'b1;
    s_data[d]  = v;
    s_last[d]  = last;
    if (do_wr) begin
      wt_we[d]   = 1'b1;
      set_addr(d, 6'd0);
      wt_data[d] = wv;
    end
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = s_ready[d];
      @(posedge clk); #1;
      guard++;
    end
    if (!ok) chk($sformatf("d%0d_beat_timeout", d), 32'd0, 32'd1);
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
    if (do_wr) begin
      wt_we[d] = 1'b0;
      chk($sformatf("d%0d_wt_err_at_beat", d), 32'(wt_err[d]), 32'(exp_err));
    end
  endtask

  task automatic send_frame(input int d, input int n, input logic [15:0] v, input int bad_last,
                            input bit gaps, input int wr_beat, input logic [15:0] wv,
                            input logic exp_err);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        @(posedge clk); #1;
      end
      send_beat(d, v, (i == n - 1) || (i == bad_last), (i == wr_beat), wv, exp_err);
    end
    @(negedge clk);
    chk($sformatf("d%0d_valid_T1", d), 32'(out_valid[d]), 32'd0);
    @(negedge clk);
    chk($sformatf("d%0d_valid_T2", d), 32'(out_valid[d]), 32'd1);
    chk($sformatf("d%0d_sready_out", d), 32'(s_ready[d]), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int d);
    int guard = 0;
    @(negedge clk);
    while (out_valid[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("d%0d_drain", d), 32'(out_valid[d]), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: one comparison per output handshake, in order of issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid[0] && out_ready[0]) begin
        if (q0.size() == 0) chk("d0_unexpected_out", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("d0_izlaz", 32'(izlaz[0]), 32'(e.iz));
          chk("d0_predznak", 32'(predznak[0]), 32'(e.pz));
        end
      end
      if (rst_n && out_valid[1] && out_ready[1]) begin
        if (q1.size() == 0) chk("d1_unexpected_out", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("d1_izlaz", 32'(izlaz[1]), 32'(e.iz));
          chk("d1_predznak", 32'(predznak[1]), 32'(e.pz));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wa4   = 2'd0;
    wa60  = 6'd0;
    for (int d = 0; d < 2; d++) begin
      wt_we[d] = 1'b0; wt_data[d] = 16'h0000; s_valid[d] = 1'b0;
      s_data[d] = 16'h0000; s_last[d] = 1'b0; out_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_valid", d), 32'(out_valid[d]), 32'd0);
      chk($sformatf("d%0d_rst_izlaz", d), 32'(izlaz[d]), 32'd0);
      chk($sformatf("d%0d_rst_predznak", d), 32'(predznak[d]), 32'd0);
      chk($sformatf("d%0d_rst_sready", d), 32'(s_ready[d]), 32'd0);
      chk($sformatf("d%0d_rst_frame_err", d), 32'(frame_err[d]), 32'd0);
      chk($sformatf("d%0d_rst_wt_err", d), 32'(wt_err[d]), 32'd0);
    end
    @(posedge clk); #1;

    // All weights zero: tie -> sign 1, LUT centre.
    push_exp(0, 16'h8000, 1'b1);
    send_frame(0, 4, 16'h1234, -1, 1'b0, -1, 16'h0000, 1'b0);
    chk("d0_frame_err_clean", 32'(frame_err[0]), 32'd0);
    wait_idle(0);

    wr(0, 6'd0, 16'h0100, 1'b0);
    wr(0, 6'd1, 16'h0100, 1'b0);
    wr(0, 6'd2, 16'h8100, 1'b0);
    wr(0, 6'd3, 16'h0000, 1'b0);
    // prod = 0x100*0x4000>>14 = 0x100; P=0x200, N=0x100 -> 0x8000 + 0x100/64.
    push_exp(0, 16'h8004, 1'b0);
    send_frame(0, 4, 16'h4000, -1, 1'b0, -1, 16'h0000, 1'b0);
    wait_idle(0);

    // Gapped input, result held 5 cycles with out_ready low.
    out_ready[0] = 1'b0;
    push_exp(0, 16'h8004, 1'b0);
    send_frame(0, 4, 16'h4000, -1, 1'b1, -1, 16'h0000, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("d0_hold_valid", 32'(out_valid[0]), 32'd1);
      chk("d0_hold_izlaz", 32'(izlaz[0]), 32'h8004);
      chk("d0_hold_sready", 32'(s_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_idle(0);

    // Write during ACC dropped; early s_last flags frame_err but frame completes.
    push_exp(0, 16'h8004, 1'b0);
    send_frame(0, 4, 16'h4000, 1, 1'b0, 2, 16'h7FFF, 1'b1);
    chk("d0_frame_err_set", 32'(frame_err[0]), 32'd1);
    wait_idle(0);

    // Write of w[0] alongside the index-0 beat: this frame uses old w[0].
    push_exp(0, 16'h8004, 1'b0);
    send_frame(0, 4, 16'h4000, -1, 1'b0, 0, 16'h8100, 1'b0);
    wait_idle(0);
    // Now w[0] negative: P=0x100, N=0x200 -> 0x8000 - 4.
    push_exp(0, 16'h7FFC, 1'b1);
    send_frame(0, 4, 16'h4000, -1, 1'b0, -1, 16'h0000, 1'b0);
    chk("d0_frame_err_sticky", 32'(frame_err[0]), 32'd1);
    wait_idle(0);

    // 60-input instance: out-of-range address, then saturation.
    wr(1, 6'd60, 16'h1234, 1'b1);
    for (int i = 0; i < 60; i++) wr(1, 6'(i), 16'h7FFF, 1'b0);
    push_exp(1, 16'hFFFF, 1'b0);
    send_frame(1, 60, 16'hFFFF, -1, 1'b0, -1, 16'h0000, 1'b0);
    chk("d1_frame_err_clean", 32'(frame_err[1]), 32'd0);
    wait_idle(1);

    // Reset mid-frame, then a clean frame sees all-zero weights.
    send_beat(0, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_beat(0, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("d0_rst2_frame_err", 32'(frame_err[0]), 32'd0);
    chk("d0_rst2_valid", 32'(out_valid[0]), 32'd0);
    chk("d0_rst2_sready", 32'(s_ready[0]), 32'd0);
    @(posedge clk); #1;
    push_exp(0, 16'h8000, 1'b1);
    send_frame(0, 4, 16'h4000, -1, 1'b0, -1, 16'h0000, 1'b0);
    wait_idle(0);

    repeat (3) @(negedge clk);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
